// File: rtl/bopit_move_to_ssd.sv
// rtl/bopit_move_to_ssd.sv - Bop-It move code (0..31) to four 7-segment glyph bytes
module bopit_move_to_ssd #(
    parameter bit BLANK_LEADING  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  move,
    output logic [31:0] ssd_digits,
    output logic        ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        ENC  = 2'd2
    } state_t;

    // All-blank display word in the selected segment polarity.
    localparam logic [31:0] BLANK_WORD = SEG_ACTIVE_LOW ? 32'hFFFF_FFFF : 32'h0000_0000;

    state_t      state_q, state_d;
    logic [4:0]  rem_q, rem_d;
    logic [1:0]  tens_q, tens_d;
    logic [31:0] digits_q, digits_d;
    logic        ready_q, ready_d;

    // Active-low glyph {dp,g,f,e,d,c,b,a}; anything outside 0..9 shows blank.
    function automatic logic [7:0] glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'd0:    g = 8'hC0;
            4'd1:    g = 8'hF9;
            4'd2:    g = 8'hA4;
            4'd3:    g = 8'hB0;
            4'd4:    g = 8'h99;
            4'd5:    g = 8'h92;
            4'd6:    g = 8'h82;
            4'd7:    g = 8'hF8;
            4'd8:    g = 8'h80;
            4'd9:    g = 8'h90;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

    logic [7:0]  tens_glyph;
    logic [31:0] enc_word;

    // Assemble the display word from the finished quotient/remainder.
    always_comb begin
        tens_glyph = glyph({2'b00, tens_q});
        if (BLANK_LEADING && (tens_q == 2'd0)) begin
            tens_glyph = 8'hFF;
        end
        enc_word = {8'hFF, 8'hFF, tens_glyph, glyph(rem_q[3:0])};
        if (!SEG_ACTIVE_LOW) begin
            enc_word = ~enc_word;
        end
    end

    // Next-state logic: accept in IDLE, divide by repeated subtraction, publish in ENC.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        tens_d   = tens_q;
        digits_d = digits_q;
        ready_d  = ready_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = move;
                    tens_d  = 2'd0;
                    ready_d = 1'b0;
                    state_d = CONV;
                end
            end
            CONV: begin
                if (rem_q >= 5'd10) begin
                    rem_d  = rem_q - 5'd10;
                    tens_d = tens_q + 2'd1;
                end else begin
                    state_d = ENC;
                end
            end
            ENC: begin
                digits_d = enc_word;
                ready_d  = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State register; reset blanks the display and abandons any conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rem_q    <= 5'd0;
            tens_q   <= 2'd0;
            digits_q <= BLANK_WORD;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            tens_q   <= tens_d;
            digits_q <= digits_d;
            ready_q  <= ready_d;
        end
    end

    assign ssd_digits = digits_q;
    assign ready      = ready_q;

endmodule

// File: tb/tb_bopit_move_to_ssd.sv
// tb/tb_bopit_move_to_ssd.sv - scoreboard bench for bopit_move_to_ssd
module tb_bopit_move_to_ssd;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  move;
    logic [31:0] digits_a, digits_b;
    logic        ready_a, ready_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        int          lat;
        int          scyc;
        logic [4:0]  mv;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prev_a, prev_b;
    logic        prev_ready;

    // Default build: blank leading zero, active-low segments.
    bopit_move_to_ssd #(.BLANK_LEADING(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .move(move),
        .ssd_digits(digits_a), .ready(ready_a)
    );

    // Alternate build: leading zero shown, inverted segment bytes.
    bopit_move_to_ssd #(.BLANK_LEADING(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .move(move),
        .ssd_digits(digits_b), .ready(ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [4:0] mv, input bit blank_lead, input bit act_low);
        logic [7:0]  tbl [10];
        int          t, o;
        logic [7:0]  tg;
        logic [31:0] w;
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        t = int'(mv) / 10;
        o = int'(mv) % 10;
        tg = (t == 0 && blank_lead) ? 8'hFF : tbl[t];
        w = {8'hFF, 8'hFF, tg, tbl[o]};
        return act_low ? w : ~w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [4:0] mv);
        exp_t e;
        e.exp_a = model(mv, 1'b1, 1'b1);
        e.exp_b = model(mv, 1'b0, 1'b0);
        e.lat   = 2 + int'(mv) / 10;
        e.scyc  = cyc;
        e.mv    = mv;
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready_a) chk("wait_ready_timeout", {31'd0, ready_a}, 32'd1);
    endtask

    // One conversion; optionally pokes start while busy, which must be ignored.
    task automatic run_conv(input logic [4:0] mv, input bit poke);
        wait_ready();
        start = 1'b1;
        move  = mv;
        @(posedge clk);
        @(negedge clk);
        push_exp(mv);
        move  = 5'($urandom);
        start = poke;
        @(negedge clk);
        start = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    // start held high through completion: a second conversion follows at once.
    task automatic run_held(input logic [4:0] mv);
        int n = 0;
        wait_ready();
        start = 1'b1;
        move  = mv;
        @(posedge clk);
        @(negedge clk);
        push_exp(mv);
        do begin
            @(negedge clk);
            n++;
        end while (!ready_a && n < 20);
        @(posedge clk);
        @(negedge clk);
        push_exp(mv);
        start = 1'b0;
    endtask

    // Monitor: pop on each ready rise; otherwise the display must hold its last value.
    initial begin
        prev_ready = 1'b1;
        prev_a = 32'hFFFF_FFFF;
        prev_b = 32'h0000_0000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ready = ready_a;
            end else if (ready_a && !prev_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk($sformatf("digits_a mv=%0d", e.mv), digits_a, e.exp_a);
                    chk($sformatf("digits_b mv=%0d", e.mv), digits_b, e.exp_b);
                    chk($sformatf("latency mv=%0d", e.mv), 32'(cyc - e.scyc), 32'(e.lat));
                    chk("ready_b_done", {31'd0, ready_b}, 32'd1);
                    prev_a = e.exp_a;
                    prev_b = e.exp_b;
                end
            end else begin
                chk("hold_a", digits_a, prev_a);
                chk("hold_b", digits_b, prev_b);
                chk("ready_match", {31'd0, ready_b}, {31'd0, ready_a});
            end
            prev_ready = ready_a;
        end
    end

    initial begin
        logic [4:0] dir [6];
        int n;
        dir = '{5'd4, 5'd10, 5'd31, 5'd0, 5'd7, 5'd9};
        rst_n = 1'b0;
        start = 1'b0;
        move  = 5'd0;
        repeat (2) @(negedge clk);
        chk("reset_ready", {31'd0, ready_a}, 32'd1);
        chk("reset_digits_a", digits_a, 32'hFFFF_FFFF);
        chk("reset_digits_b", digits_b, 32'h0000_0000);
        rst_n = 1'b1;
        move  = 5'd17;
        repeat (4) @(negedge clk);

        foreach (dir[i]) run_conv(dir[i], 1'b0);
        run_conv(5'd31, 1'b1);
        wait_ready();
        start = 1'b1;
        move  = 5'd31;
        @(posedge clk);
        @(negedge clk);
        push_exp(5'd31);
        start = 1'b1;
        move  = 5'd20;
        @(negedge clk);
        start = 1'b0;
        run_held(5'd12);

        for (int i = 0; i < 40; i++) begin
            run_conv(5'($urandom), 1'($urandom));
        end

        // Reset in the middle of a long conversion discards the result.
        wait_ready();
        start = 1'b1;
        move  = 5'd31;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_ready", {31'd0, ready_a}, 32'd1);
        chk("midreset_digits_a", digits_a, 32'hFFFF_FFFF);
        chk("midreset_digits_b", digits_b, 32'h0000_0000);
        sb.delete();
        prev_a = 32'hFFFF_FFFF;
        prev_b = 32'h0000_0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_conv(5'($urandom), 1'($urandom));
        end

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
